// File: rtl/fp_align_pkg.sv
// Shared widths and stage payload for the floating-point alignment pipe.
// Payload widths follow the default EXP_W/MAN_W; override both together.
package fp_align_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_GRD_W = 3;
  localparam int FP_AW    = FP_MAN_W + 1 + FP_GRD_W;

  typedef struct packed {
    logic [FP_AW-1:0]    sig_big;
    logic [FP_AW-1:0]    sig_sml;
    logic [FP_EXP_W-1:0] exp;
    logic                swap;
    logic                eop;
    logic [FP_EXP_W-1:0] d;
  } align_stage_t;
endpackage

// File: rtl/fp_shr_sticky.sv
// Right shifter that also reports whether any set bit fell off the end.
module fp_shr_sticky #(
  parameter int AW = 27,
  parameter int SW = 8
) (
  input  logic [AW-1:0] value,
  input  logic [SW-1:0] amount,
  output logic [AW-1:0] shifted,
  output logic          sticky
);
  logic [2*AW-1:0] ext;

  always_comb begin
    ext     = {value, {AW{1'b0}}} >> amount;
    shifted = ext[2*AW-1:AW];
    sticky  = |ext[AW-1:0];
    // Shifts past the word lose everything; the lower half alone misses bits.
    if (32'(amount) >= AW) begin
      shifted = '0;
      sticky  = |value;
    end
  end
endmodule

// File: rtl/fp_align_pipe.sv
// 3-stage FP operand alignment: compare, shift with sticky, invert/output.
// Define FP_ALIGN_SUBNORM_EN to treat exponent 0 as subnormal instead of zero.
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] mx,
  input  logic [MAN_W-1:0] my,
  input  logic [EXP_W-1:0] ex,
  input  logic [EXP_W-1:0] ey,
  input  logic             eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W+3:0] out_big,
  output logic [MAN_W+3:0] out_small,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_swap,
  output logic             out_sticky
);
  localparam int AW     = MAN_W + 1 + FP_GRD_W;
  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  logic            adv;

  // Whole pipe moves as one; it only freezes when the output is blocked.
  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // S1: effective exponents, significands, compare
  logic [EXP_W-1:0] ex_e, ey_e;
  logic [AW-1:0]    sx, sy;
  logic             x_big;
  align_stage_t     s1_n, s1;

`ifdef FP_ALIGN_SUBNORM_EN
  assign ex_e = (ex == '0) ? EXP_W'(1) : ex;
  assign ey_e = (ey == '0) ? EXP_W'(1) : ey;
  assign sx   = {(ex != '0), mx, {FP_GRD_W{1'b0}}};
  assign sy   = {(ey != '0), my, {FP_GRD_W{1'b0}}};
`else
  assign ex_e = ex;
  assign ey_e = ey;
  assign sx   = (ex == '0) ? '0 : {1'b1, mx, {FP_GRD_W{1'b0}}};
  assign sy   = (ey == '0) ? '0 : {1'b1, my, {FP_GRD_W{1'b0}}};
`endif

  assign x_big = (ex_e > ey_e) || ((ex_e == ey_e) && (sx >= sy));

  always_comb begin
    s1_n         = '0;
    s1_n.sig_big = x_big ? sx : sy;
    s1_n.sig_sml = x_big ? sy : sx;
    s1_n.exp     = x_big ? ex_e : ey_e;
    s1_n.swap    = !x_big;
    s1_n.eop     = eop;
    s1_n.d       = x_big ? (ex_e - ey_e) : (ey_e - ex_e);
  end

  // S2: shift the smaller operand, fold sticky into its LSB
  logic [AW-1:0]    sh_val;
  logic             sh_st;
  logic [AW-1:0]    s2_big, s2_sml;
  logic [EXP_W-1:0] s2_exp;
  logic             s2_swap, s2_eop, s2_st;

  fp_shr_sticky #(.AW(AW), .SW(EXP_W)) u_shr (
    .value  (s1.sig_sml),
    .amount (s1.d),
    .shifted(sh_val),
    .sticky (sh_st)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1         <= '0;
      s2_big     <= '0;
      s2_sml     <= '0;
      s2_exp     <= '0;
      s2_swap    <= 1'b0;
      s2_eop     <= 1'b0;
      s2_st      <= 1'b0;
      out_big    <= '0;
      out_small  <= '0;
      out_exp    <= '0;
      out_swap   <= 1'b0;
      out_sticky <= 1'b0;
    end else if (adv) begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid};
      s1         <= s1_n;
      s2_big     <= s1.sig_big;
      s2_sml     <= sh_val | {{(AW-1){1'b0}}, sh_st};
      s2_exp     <= s1.exp;
      s2_swap    <= s1.swap;
      s2_eop     <= s1.eop;
      s2_st      <= sh_st;
      // S3: subtraction takes the one's complement of the smaller operand
      out_big    <= s2_big;
      out_small  <= s2_eop ? ~s2_sml : s2_sml;
      out_exp    <= s2_exp;
      out_swap   <= s2_swap;
      out_sticky <= s2_st;
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe: directed vectors, stall/reset sequences, and
// random traffic against an arithmetic reference model with a scoreboard.
module tb_fp_align_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int AW    = MAN_W + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, out_ready = 1'b1, eop = 1'b0;
  logic             in_ready, out_valid, out_swap, out_sticky;
  logic [MAN_W-1:0] mx = '0, my = '0;
  logic [EXP_W-1:0] ex = '0, ey = '0, out_exp;
  logic [AW-1:0]    out_big, out_small;

  always #5 clk = ~clk;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mx(mx), .my(my), .ex(ex), .ey(ey), .eop(eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_big(out_big), .out_small(out_small), .out_exp(out_exp),
    .out_swap(out_swap), .out_sticky(out_sticky)
  );

  typedef struct {
    logic [AW-1:0]    big;
    logic [AW-1:0]    sml;
    logic [EXP_W-1:0] exp;
    logic             swap;
    logic             sticky;
  } res_t;

  typedef struct {
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] mx, my;
    logic             eop;
    res_t             r;
  } vec_t;

  res_t sb[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  // Significands as integers, alignment as division by 2**d.
  function automatic res_t ref_model(input int xe, input int xm, input int ye, input int ym,
                                     input bit op);
    res_t   r;
    longint sx, sy, sb_, ss, q, rm, p;
    int     exe, eye, d;
    bit     swp;
`ifdef FP_ALIGN_SUBNORM_EN
    exe = (xe == 0) ? 1 : xe;
    eye = (ye == 0) ? 1 : ye;
    sx  = ((xe != 0 ? (longint'(1) << MAN_W) : 0) + xm) * 8;
    sy  = ((ye != 0 ? (longint'(1) << MAN_W) : 0) + ym) * 8;
`else
    exe = xe;
    eye = ye;
    sx  = (xe == 0) ? 0 : ((longint'(1) << MAN_W) + xm) * 8;
    sy  = (ye == 0) ? 0 : ((longint'(1) << MAN_W) + ym) * 8;
`endif
    swp = (eye > exe) || (eye == exe && sy > sx);
    sb_ = swp ? sy : sx;
    ss  = swp ? sx : sy;
    d   = swp ? eye - exe : exe - eye;
    if (d >= AW) begin
      q  = 0;
      rm = ss;
    end else begin
      p  = longint'(1) << d;
      q  = ss / p;
      rm = ss % p;
    end
    r.sticky = (rm != 0);
    q        = q + ((r.sticky && (q % 2 == 0)) ? 1 : 0);
    if (op) q = ((longint'(1) << AW) - 1) - q;
    r.big  = AW'(sb_);
    r.sml  = AW'(q);
    r.exp  = EXP_W'(swp ? eye : exe);
    r.swap = swp;
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(ref_model(ex, mx, ey, my, eop));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          res_t e;
          e = sb.pop_front();
          chk("sb_big", out_big, e.big);
          chk("sb_small", out_small, e.sml);
          chk("sb_exp", out_exp, e.exp);
          chk("sb_swap", out_swap, e.swap);
          chk("sb_sticky", out_sticky, e.sticky);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand();
    ex  = EXP_W'($urandom_range(0, 255));
    ey  = ($urandom % 2) ? EXP_W'(int'(ex) + $urandom_range(0, 30)) : EXP_W'($urandom_range(0, 255));
    mx  = MAN_W'($urandom);
    my  = ($urandom % 8 == 0) ? mx : MAN_W'($urandom);
    if ($urandom % 8 == 0) ey = ex;
    eop = $urandom % 2;
  endtask

  vec_t tv[6];
  int   lat, sent, hi;
  logic [AW-1:0]    h_big, h_sml;
  logic [EXP_W-1:0] h_exp;

  initial begin
    tv[0] = '{ex:127, mx:0, ey:126, my:0, eop:0,
              r:'{big:27'h4000000, sml:27'h2000000, exp:127, swap:0, sticky:0}};
    tv[1] = '{ex:150, mx:0, ey:127, my:1, eop:0,
              r:'{big:27'h4000000, sml:27'h0000009, exp:150, swap:0, sticky:1}};
    tv[2] = '{ex:127, mx:23'h400000, ey:127, my:0, eop:1,
              r:'{big:27'h6000000, sml:27'h3FFFFFF, exp:127, swap:0, sticky:0}};
    tv[3] = '{ex:127, mx:0, ey:127, my:23'h400000, eop:1,
              r:'{big:27'h6000000, sml:27'h3FFFFFF, exp:127, swap:1, sticky:0}};
    tv[4] = '{ex:100, mx:23'h123456, ey:200, my:0, eop:0,
              r:'{big:27'h4000000, sml:27'h0000001, exp:200, swap:1, sticky:1}};
`ifdef FP_ALIGN_SUBNORM_EN
    tv[5] = '{ex:0, mx:23'h400000, ey:127, my:0, eop:0,
              r:'{big:27'h4000000, sml:27'h0000001, exp:127, swap:1, sticky:1}};
`else
    tv[5] = '{ex:0, mx:23'h400000, ey:127, my:0, eop:0,
              r:'{big:27'h4000000, sml:27'h0000000, exp:127, swap:1, sticky:0}};
`endif

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_big", out_big, 0);
    chk("rst_out_small", out_small, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_swap_sticky", {out_swap, out_sticky}, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors with latency measurement
    for (int i = 0; i < 6; i++) begin
      ex = tv[i].ex; mx = tv[i].mx; ey = tv[i].ey; my = tv[i].my; eop = tv[i].eop;
      in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin cyc(); lat++; end
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_big", i), out_big, tv[i].r.big);
      chk($sformatf("v%0d_small", i), out_small, tv[i].r.sml);
      chk($sformatf("v%0d_exp", i), out_exp, tv[i].r.exp);
      chk($sformatf("v%0d_swap", i), out_swap, tv[i].r.swap);
      chk($sformatf("v%0d_sticky", i), out_sticky, tv[i].r.sticky);
      cyc();
    end

    // Back-to-back into a blocked output
    out_ready = 1'b0; sent = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      ex = EXP_W'(120 + sent); mx = MAN_W'(sent * 1000); ey = 118; my = 7; eop = sent[0];
      #1;
      if (c == 3) begin h_big = out_big; h_sml = out_small; h_exp = out_exp; end
      if (c == 5) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepted", sent, 3);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_hold_big", out_big, h_big);
        chk("stall_hold_small", out_small, h_sml);
        chk("stall_hold_exp", out_exp, h_exp);
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (sent < 5 || sb.size() != 0); c++) begin
      in_valid = (sent < 5);
      ex = EXP_W'(120 + sent); mx = MAN_W'(sent * 1000); ey = 118; my = 7; eop = sent[0];
      #1;
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid = 1'b0;
    chk("stall_all_sent", sent, 5);
    chk("stall_drained", sb.size(), 0);

    // Reset with two transfers in flight
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; set_rand();
      cyc();
    end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    chk("midrst_out_valid", out_valid, 0);
    sb.delete();
    rst = 1'b0;
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) hi++;
      cyc();
    end
    chk("midrst_no_stale", hi, 0);
    chk("midrst_in_ready", in_ready, 1);

    // Random traffic with random backpressure
    sent = 0; in_valid = 1'b0;
    for (int c = 0; c < 3000 && sent < 300; c++) begin
      out_ready = ($urandom % 4) != 0;
      if (!in_valid) begin
        in_valid = ($urandom % 3) != 0;
        set_rand();
      end
      #1;
      if (in_valid && in_ready) begin sent++; in_valid = 1'b0; end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) cyc();
    chk("rand_sent", sent, 300);
    chk("rand_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_align_pipe.md
FP_ALIGN_PIPE -- requirements
Module: fp_align_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; aligned word width AW = MAN_W+4 (hidden, fraction, guard, round, sticky).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-006 SHALL have ports mx and my, input, MAN_W each, operand fractions.
REQ-007 SHALL have ports ex and ey, input, EXP_W each, biased exponents.
REQ-008 SHALL have port eop, input, 1, effective operation: 0 add, 1 subtract.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-010 SHALL have ports out_big and out_small, output, AW each, aligned operands.
REQ-011 SHALL have port out_exp, output, EXP_W, larger effective exponent.
REQ-012 SHALL have ports out_swap output 1 (1 = y is larger) and out_sticky output 1 (OR of shifted-out bits).

Function
REQ-013 SHALL accept a transfer when in_valid&&in_ready and emit it when out_valid&&out_ready; in-order, one transfer per cycle peak, no loss or duplication.
REQ-014 SHALL have latency exactly 3 cycles when unstalled: S1 compare, S2 shift, S3 invert/output register.
REQ-015 S1 SHALL compute d=|ex-ey|; larger = operand with greater exponent; on equal exponents, the operand with greater-or-equal fraction, with x winning ties (out_swap=0).
REQ-016 S1 SHALL form each significand as {hidden, fraction, 3'b000}, hidden=1 for nonzero exponent.
REQ-017 S2 SHALL shift the smaller significand right by d; for d >= AW the shifted value SHALL be 0 and every shifted-out bit SHALL count toward sticky.
REQ-018 S2 SHALL OR all shifted-out bits into out_sticky and into bit 0 of the shifted word.
REQ-019 S3 SHALL drive out_small as the one's complement of the shifted word when eop=1, else unmodified; out_big SHALL never be inverted.
REQ-020 Stall: in_ready = !(S3 full) || out_ready; a stalled pipe SHALL hold all stage registers and outputs stable.
REQ-021 Outputs SHALL change only on an accepted output transfer or a bubble advance; out_valid SHALL not drop without a transfer.

Reset
REQ-022 On rst=1 at a clock edge, all stage valid bits SHALL clear, and out_valid, out_big, out_small, out_exp, out_swap and out_sticky SHALL go to 0.
REQ-023 in_ready SHALL be 1 from the first cycle after reset.
REQ-024 Reset mid-operation SHALL discard all in-flight transfers; no partial output SHALL appear afterwards.

Configuration
REQ-025 With FP_ALIGN_SUBNORM_EN defined, an exponent of 0 SHALL give hidden=0 and an effective exponent of 1 for d and out_exp.
REQ-026 Without FP_ALIGN_SUBNORM_EN, an operand with exponent 0 SHALL be flushed to a zero significand (effective exponent 0); the port list SHALL be identical in both builds.

Structure
REQ-027 A shared package fp_align_pkg SHALL hold the defaults for EXP_W and MAN_W, the guard-bit count (3), and a typedef for the stage payload struct (big, small, exp, swap, eop, d).
REQ-028 The shifter-with-sticky SHALL be one sub-module, fp_shr_sticky (inputs: value, amount; outputs: shifted, sticky), combinational, instanced in S2.

Verification
REQ-029 Defaults: ex=127, mx=0, ey=126, my=0, eop=0 -> 3 cycles later out_big=27'h4000000, out_small=27'h2000000, out_exp=127, out_swap=0, out_sticky=0.
REQ-030 ex=150, mx=0, ey=127, my=23'h000001, eop=0 -> out_small=27'h0000009, out_sticky=1, out_exp=150.
REQ-031 ex=ey=127, mx=23'h400000, my=0, eop=1 -> out_big=27'h6000000, out_small=27'h3FFFFFF, out_swap=0; the same with x/y exchanged -> out_swap=1, identical data.
REQ-032 ey=200, ex=100, mx=nonzero -> out_small=27'h0000001, out_sticky=1, out_swap=1, out_exp=200.
REQ-033 Five back-to-back inputs with out_ready low for 6 cycles -> in_ready drops once 3 are held, outputs stay stable, all 5 emerge in order once out_ready=1.
REQ-034 rst pulsed with 2 in flight -> out_valid=0 the next cycle, no stale output; ex=0, mx=23'h400000 in both macro builds -> hidden bit 0 with the macro, out_small/out_big zero-significand without it.
